// File: rtl/bch_dec_ctrl.sv
// bch_dec_ctrl: two-requester front end for a shared BCH(15,7) decoder core.
// Round-robin arbitration between two requesters, one job in flight at a
// time, a bounded wait for the core with timeout fallback, and a held
// response until the consumer takes it.
// Optional statistics counters are compiled in with the macro
// BCH_DEC_CTRL_STATS_EN (adds o_stat_jobs, o_stat_uncorr, o_stat_timeouts).
module bch_dec_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 32
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req0_valid,
  input  logic [14:0] i_req0_codeword,
  output logic        o_req0_ready,
  input  logic        i_req1_valid,
  input  logic [14:0] i_req1_codeword,
  output logic        o_req1_ready,
  output logic        o_core_start,
  output logic [14:0] o_core_codeword,
  input  logic        i_core_done,
  input  logic [14:0] i_core_corrected,
  input  logic        i_core_error_flag,
  output logic        o_rsp_valid,
  input  logic        i_rsp_ready,
  output logic        o_rsp_id,
  output logic [14:0] o_rsp_codeword,
  output logic        o_rsp_error_flag,
  output logic        o_rsp_timeout,
  output logic        o_busy
`ifdef BCH_DEC_CTRL_STATS_EN
  ,
  output logic [7:0]  o_stat_jobs,
  output logic [7:0]  o_stat_uncorr,
  output logic [7:0]  o_stat_timeouts
`endif
);

  localparam logic [7:0] LP_TIMEOUT = 8'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t      r_state;
  logic        r_last_grant;
  logic [7:0]  r_wait_cnt;
  logic        r_core_start;
  logic [14:0] r_core_codeword;
  logic        r_rsp_valid;
  logic        r_rsp_id;
  logic [14:0] r_rsp_codeword;
  logic        r_rsp_error_flag;
  logic        r_rsp_timeout;
  logic        r_busy;

  logic        w_grant_vld;
  logic        w_grant_id;
  logic        w_accept;
  logic [14:0] w_sel_codeword;

  // Round-robin pick: on a tie the channel not served last wins.
  always_comb begin
    w_grant_vld = 1'b0;
    w_grant_id  = 1'b0;
    if (i_req0_valid && i_req1_valid) begin
      w_grant_vld = 1'b1;
      w_grant_id  = ~r_last_grant;
    end else if (i_req0_valid) begin
      w_grant_vld = 1'b1;
      w_grant_id  = 1'b0;
    end else if (i_req1_valid) begin
      w_grant_vld = 1'b1;
      w_grant_id  = 1'b1;
    end else begin
      w_grant_vld = 1'b0;
      w_grant_id  = 1'b0;
    end
  end

  // Ready only toward the granted channel, only while idle and out of reset.
  assign w_accept       = (r_state == S_IDLE) && w_grant_vld && !i_rst;
  assign o_req0_ready   = w_accept && (w_grant_id == 1'b0);
  assign o_req1_ready   = w_accept && (w_grant_id == 1'b1);
  assign w_sel_codeword = w_grant_id ? i_req1_codeword : i_req0_codeword;

  // Job sequencing: accept, start pulse, bounded wait for the core, response hold.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state          <= S_IDLE;
      r_last_grant     <= 1'b1;
      r_wait_cnt       <= 8'd0;
      r_core_start     <= 1'b0;
      r_core_codeword  <= 15'd0;
      r_rsp_valid      <= 1'b0;
      r_rsp_id         <= 1'b0;
      r_rsp_codeword   <= 15'd0;
      r_rsp_error_flag <= 1'b0;
      r_rsp_timeout    <= 1'b0;
      r_busy           <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_core_codeword <= w_sel_codeword;
            r_rsp_id        <= w_grant_id;
            r_last_grant    <= w_grant_id;
            r_core_start    <= 1'b1;
            r_busy          <= 1'b1;
            r_state         <= S_START;
          end
        end
        S_START: begin
          // core_done is deliberately not looked at here
          r_core_start <= 1'b0;
          r_wait_cnt   <= 8'd1;
          r_state      <= S_WAIT;
        end
        S_WAIT: begin
          if (i_core_done) begin
            // done wins even on the timeout cycle
            r_rsp_codeword   <= i_core_corrected;
            r_rsp_error_flag <= i_core_error_flag;
            r_rsp_timeout    <= 1'b0;
            r_rsp_valid      <= 1'b1;
            r_wait_cnt       <= 8'd0;
            r_state          <= S_RESP;
          end else if (r_wait_cnt == LP_TIMEOUT) begin
            // core gave up on us: hand back the received word unchanged
            r_rsp_codeword   <= r_core_codeword;
            r_rsp_error_flag <= 1'b1;
            r_rsp_timeout    <= 1'b1;
            r_rsp_valid      <= 1'b1;
            r_wait_cnt       <= 8'd0;
            r_state          <= S_RESP;
          end else begin
            r_wait_cnt <= r_wait_cnt + 8'd1;
          end
        end
        S_RESP: begin
          if (i_rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state      <= S_IDLE;
          r_core_start <= 1'b0;
          r_rsp_valid  <= 1'b0;
          r_busy       <= 1'b0;
          r_wait_cnt   <= 8'd0;
        end
      endcase
    end
  end

  assign o_core_start     = r_core_start;
  assign o_core_codeword  = r_core_codeword;
  assign o_rsp_valid      = r_rsp_valid;
  assign o_rsp_id         = r_rsp_id;
  assign o_rsp_codeword   = r_rsp_codeword;
  assign o_rsp_error_flag = r_rsp_error_flag;
  assign o_rsp_timeout    = r_rsp_timeout;
  assign o_busy           = r_busy;

`ifdef BCH_DEC_CTRL_STATS_EN
  logic [7:0] r_stat_jobs;
  logic [7:0] r_stat_uncorr;
  logic [7:0] r_stat_timeouts;
  logic       w_rsp_fire;

  assign w_rsp_fire = (r_state == S_RESP) && i_rsp_ready;

  // Saturating job statistics, counted when a response is handed over.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_stat_jobs     <= 8'd0;
      r_stat_uncorr   <= 8'd0;
      r_stat_timeouts <= 8'd0;
    end else if (w_rsp_fire) begin
      if (r_stat_jobs != 8'hFF) begin
        r_stat_jobs <= r_stat_jobs + 8'd1;
      end
      if (r_rsp_error_flag && !r_rsp_timeout && (r_stat_uncorr != 8'hFF)) begin
        r_stat_uncorr <= r_stat_uncorr + 8'd1;
      end
      if (r_rsp_timeout && (r_stat_timeouts != 8'hFF)) begin
        r_stat_timeouts <= r_stat_timeouts + 8'd1;
      end
    end
  end

  assign o_stat_jobs     = r_stat_jobs;
  assign o_stat_uncorr   = r_stat_uncorr;
  assign o_stat_timeouts = r_stat_timeouts;
`endif

endmodule

// File: tb/tb_bch_dec_ctrl.sv
// Self-checking bench for bch_dec_ctrl: directed cases plus randomized jobs
// checked against a job-level reference model (arbitration pointer, expected
// response per job, statistics tallies).
module tb_bch_dec_ctrl;
  localparam int T = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req0_valid, i_req1_valid;
  logic [14:0] i_req0_codeword, i_req1_codeword;
  logic        o_req0_ready, o_req1_ready;
  logic        o_core_start;
  logic [14:0] o_core_codeword;
  logic        i_core_done;
  logic [14:0] i_core_corrected;
  logic        i_core_error_flag;
  logic        o_rsp_valid;
  logic        i_rsp_ready;
  logic        o_rsp_id;
  logic [14:0] o_rsp_codeword;
  logic        o_rsp_error_flag;
  logic        o_rsp_timeout;
  logic        o_busy;
`ifdef BCH_DEC_CTRL_STATS_EN
  logic [7:0]  o_stat_jobs, o_stat_uncorr, o_stat_timeouts;
`endif

  bch_dec_ctrl #(.TIMEOUT_CYCLES(T)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_req0_valid(i_req0_valid), .i_req0_codeword(i_req0_codeword), .o_req0_ready(o_req0_ready),
    .i_req1_valid(i_req1_valid), .i_req1_codeword(i_req1_codeword), .o_req1_ready(o_req1_ready),
    .o_core_start(o_core_start), .o_core_codeword(o_core_codeword),
    .i_core_done(i_core_done), .i_core_corrected(i_core_corrected),
    .i_core_error_flag(i_core_error_flag),
    .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready), .o_rsp_id(o_rsp_id),
    .o_rsp_codeword(o_rsp_codeword), .o_rsp_error_flag(o_rsp_error_flag),
    .o_rsp_timeout(o_rsp_timeout), .o_busy(o_busy)
`ifdef BCH_DEC_CTRL_STATS_EN
    , .o_stat_jobs(o_stat_jobs), .o_stat_uncorr(o_stat_uncorr),
    .o_stat_timeouts(o_stat_timeouts)
`endif
  );

  always #5 clk = ~clk;

  int   n_cmp  = 0;
  int   n_fail = 0;
  int   cyc    = 0;
  logic m_last;     // model: channel served last
  int   m_jobs, m_uncorr, m_to;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic do_reset();
    rst = 1'b1;
    i_req0_valid = 1'b1; i_req1_valid = 1'b1;
    i_req0_codeword = 15'h1234; i_req1_codeword = 15'h4321;
    i_core_done = 1'b0; i_core_corrected = 15'd0; i_core_error_flag = 1'b0;
    i_rsp_ready = 1'b0;
    @(posedge clk); #1;
    m_last = 1'b1; m_jobs = 0; m_uncorr = 0; m_to = 0;
    i_req0_valid = 1'b0; i_req1_valid = 1'b0;
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    i_req0_valid = 1'b1; i_req1_valid = 1'b1;
    i_req0_codeword = 15'h7FFF; i_req1_codeword = 15'h7FFF;
    i_core_done = 1'b1; i_core_corrected = 15'h7FFF; i_core_error_flag = 1'b1;
    i_rsp_ready = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if ({o_req0_ready, o_req1_ready, o_core_start, o_rsp_valid, o_rsp_id,
         o_rsp_error_flag, o_rsp_timeout, o_busy} !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got rdy0=%b rdy1=%b start=%b rv=%b id=%b err=%b to=%b busy=%b, want all 0",
               o_req0_ready, o_req1_ready, o_core_start, o_rsp_valid, o_rsp_id,
               o_rsp_error_flag, o_rsp_timeout, o_busy);
    end
    n_cmp++;
    if ({o_core_codeword, o_rsp_codeword} !== 30'd0) begin
      n_fail++;
      $display("FAIL reset_data: got core_cw=%h rsp_cw=%h, want 0 0", o_core_codeword, o_rsp_codeword);
    end
`ifdef BCH_DEC_CTRL_STATS_EN
    n_cmp++;
    if ({o_stat_jobs, o_stat_uncorr, o_stat_timeouts} !== 24'd0) begin
      n_fail++;
      $display("FAIL reset_stats: got %0d %0d %0d, want 0 0 0", o_stat_jobs, o_stat_uncorr, o_stat_timeouts);
    end
`endif
    i_core_done = 1'b0;
    do_reset();
  endtask

  // One complete job. d = WAIT cycle on which core_done rises (0 or >T: never).
  task automatic run_job(input logic v0, input logic v1,
                         input logic [14:0] cw0, input logic [14:0] cw1,
                         input int d, input logic [14:0] corr, input logic flag,
                         input int rdly, output int acc_cyc);
    logic        exp_id;
    logic [14:0] exp_cw, exp_rcw;
    logic        exp_err, exp_to;
    int          wend;
    exp_id = (v0 && v1) ? ~m_last : v1;
    exp_cw = exp_id ? cw1 : cw0;
    i_req0_valid = v0; i_req1_valid = v1;
    i_req0_codeword = cw0; i_req1_codeword = cw1;
    #1;
    n_cmp++;
    if ({o_req0_ready, o_req1_ready, o_busy} !== {exp_id == 1'b0, exp_id == 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL grant_ready: got rdy0=%b rdy1=%b busy=%b, want grant to %0d, busy 0",
               o_req0_ready, o_req1_ready, o_busy, exp_id);
    end
    @(posedge clk); #1;
    acc_cyc = cyc;
    m_last = exp_id;
    i_req0_valid = 1'b0; i_req1_valid = 1'b0;
    i_req0_codeword = 15'($urandom); i_req1_codeword = 15'($urandom);
    n_cmp++;
    if ({o_core_start, o_busy, o_rsp_id, o_core_codeword} !== {1'b1, 1'b1, exp_id, exp_cw}) begin
      n_fail++;
      $display("FAIL start: got start=%b busy=%b id=%b cw=%h, want 1 1 %b %h",
               o_core_start, o_busy, o_rsp_id, o_core_codeword, exp_id, exp_cw);
    end
    // a done pulse in the start cycle must be ignored
    i_core_done = 1'($urandom_range(0, 1));
    i_core_corrected = 15'($urandom); i_core_error_flag = 1'($urandom_range(0, 1));
    @(posedge clk); #1;
    wend = (d >= 1 && d <= T) ? d : T;
    for (int w = 1; w <= wend; w++) begin
      n_cmp++;
      if ({o_core_start, o_rsp_valid, o_busy, o_core_codeword} !== {1'b0, 1'b0, 1'b1, exp_cw}) begin
        n_fail++;
        $display("FAIL wait_cycle%0d: got start=%b rv=%b busy=%b cw=%h, want 0 0 1 %h",
                 w, o_core_start, o_rsp_valid, o_busy, o_core_codeword, exp_cw);
      end
      i_core_done = (w == d);
      i_core_corrected = (w == d) ? corr : 15'($urandom);
      i_core_error_flag = (w == d) ? flag : 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    i_core_done = 1'b0;
    if (d >= 1 && d <= T) begin
      exp_rcw = corr; exp_err = flag; exp_to = 1'b0;
    end else begin
      exp_rcw = exp_cw; exp_err = 1'b1; exp_to = 1'b1;
    end
    for (int k = 0; k <= rdly; k++) begin
      n_cmp++;
      if ({o_rsp_valid, o_busy, o_rsp_id, o_rsp_codeword, o_rsp_error_flag, o_rsp_timeout} !==
          {1'b1, 1'b1, exp_id, exp_rcw, exp_err, exp_to}) begin
        n_fail++;
        $display("FAIL resp_hold%0d: got rv=%b busy=%b id=%b cw=%h err=%b to=%b, want 1 1 %b %h %b %b",
                 k, o_rsp_valid, o_busy, o_rsp_id, o_rsp_codeword, o_rsp_error_flag,
                 o_rsp_timeout, exp_id, exp_rcw, exp_err, exp_to);
      end
`ifdef BCH_DEC_CTRL_STATS_EN
      n_cmp++;
      if ({o_stat_jobs, o_stat_uncorr, o_stat_timeouts} !== {8'(m_jobs), 8'(m_uncorr), 8'(m_to)}) begin
        n_fail++;
        $display("FAIL stats_hold: got %0d %0d %0d, want %0d %0d %0d",
                 o_stat_jobs, o_stat_uncorr, o_stat_timeouts, m_jobs, m_uncorr, m_to);
      end
`endif
      i_rsp_ready = (k == rdly);
      i_core_done = 1'($urandom_range(0, 1));
      i_req0_valid = 1'($urandom_range(0, 1)); i_req1_valid = 1'($urandom_range(0, 1));
      #1;
      n_cmp++;
      if ({o_req0_ready, o_req1_ready} !== 2'b00) begin
        n_fail++;
        $display("FAIL busy_ready: got rdy0=%b rdy1=%b, want 0 0", o_req0_ready, o_req1_ready);
      end
      @(posedge clk); #1;
    end
    i_rsp_ready = 1'b0; i_core_done = 1'b0;
    i_req0_valid = 1'b0; i_req1_valid = 1'b0;
    if (m_jobs < 255) m_jobs++;
    if (exp_err && !exp_to && m_uncorr < 255) m_uncorr++;
    if (exp_to && m_to < 255) m_to++;
    n_cmp++;
    if ({o_rsp_valid, o_busy} !== 2'b00) begin
      n_fail++;
      $display("FAIL resp_done: got rv=%b busy=%b, want 0 0", o_rsp_valid, o_busy);
    end
`ifdef BCH_DEC_CTRL_STATS_EN
    n_cmp++;
    if ({o_stat_jobs, o_stat_uncorr, o_stat_timeouts} !== {8'(m_jobs), 8'(m_uncorr), 8'(m_to)}) begin
      n_fail++;
      $display("FAIL stats_after: got %0d %0d %0d, want %0d %0d %0d",
               o_stat_jobs, o_stat_uncorr, o_stat_timeouts, m_jobs, m_uncorr, m_to);
    end
`endif
  endtask

  task automatic test_case1();
    int a;
    run_job(1'b1, 1'b0, 15'b000100100000000, 15'd0, 3, 15'd0, 1'b0, 1, a);
  endtask

  task automatic test_back_to_back();
    int a, prev;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      run_job(1'b1, 1'b1, 15'($urandom), 15'($urandom), 1, 15'($urandom), 1'b0, 0, a);
      n_cmp++;
      if (o_rsp_id !== 1'(i % 2)) begin
        n_fail++;
        $display("FAIL alternate%0d: got id=%b, want %0d", i, o_rsp_id, i % 2);
      end
      if (i > 0) begin
        n_cmp++;
        if (a - prev !== 4) begin
          n_fail++;
          $display("FAIL spacing%0d: got %0d cycles, want 4", i, a - prev);
        end
      end
      prev = a;
    end
  endtask

  task automatic test_timeout();
    int a;
    run_job(1'b0, 1'b1, 15'd0, 15'h2AB3, 0, 15'd0, 1'b0, 0, a);   // never done
    run_job(1'b1, 1'b0, 15'h1C0F, 15'd0, T, 15'h1C00, 1'b0, 0, a); // done on last cycle
    run_job(1'b1, 1'b1, 15'h0F0F, 15'h7070, T + 3, 15'd5, 1'b0, 1, a); // too late
  endtask

  task automatic test_reset_midjob();
    int a;
    do_reset();
    i_req0_valid = 1'b1; i_req0_codeword = 15'h3333;
    @(posedge clk); #1;
    i_req0_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({o_busy, o_rsp_valid, o_core_start, o_core_codeword} !== 18'd0) begin
      n_fail++;
      $display("FAIL midjob_reset: got busy=%b rv=%b start=%b cw=%h, want 0 0 0 0",
               o_busy, o_rsp_valid, o_core_start, o_core_codeword);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    m_last = 1'b1; m_jobs = 0; m_uncorr = 0; m_to = 0;
    for (int i = 0; i < 3; i++) begin
      i_core_done = 1'b1; i_core_corrected = 15'h7FFF; i_core_error_flag = 1'b1;
      @(posedge clk); #1;
      n_cmp++;
      if ({o_busy, o_rsp_valid} !== 2'b00) begin
        n_fail++;
        $display("FAIL late_done%0d: got busy=%b rv=%b, want 0 0", i, o_busy, o_rsp_valid);
      end
    end
    i_core_done = 1'b0;
    run_job(1'b1, 1'b1, 15'h0101, 15'h0202, 2, 15'h0100, 1'b0, 0, a);
    n_cmp++;
    if (o_rsp_id !== 1'b0) begin
      n_fail++;
      $display("FAIL tie_after_reset: got id=%b, want 0", o_rsp_id);
    end
  endtask

  task automatic test_random();
    int a, d, r;
    logic v0, v1;
    for (int i = 0; i < 30; i++) begin
      r = $urandom_range(0, 9);
      if (r == 0)      d = 0;
      else if (r == 1) d = T;
      else if (r == 2) d = T + 2;
      else             d = $urandom_range(1, 6);
      v0 = 1'($urandom_range(0, 1));
      v1 = v0 ? 1'($urandom_range(0, 1)) : 1'b1;
      run_job(v0, v1, 15'($urandom), 15'($urandom), d, 15'($urandom),
              1'($urandom_range(0, 1)), $urandom_range(0, 3), a);
    end
  endtask

`ifdef BCH_DEC_CTRL_STATS_EN
  task automatic test_stats();
    int a;
    do_reset();
    run_job(1'b1, 1'b0, 15'h0011, 15'd0, 2, 15'h0010, 1'b0, 2, a);
    run_job(1'b0, 1'b1, 15'd0, 15'h5555, 4, 15'h5555, 1'b1, 2, a);
    run_job(1'b1, 1'b0, 15'h6666, 15'd0, 0, 15'd0, 1'b0, 2, a);
    n_cmp++;
    if ({o_stat_jobs, o_stat_uncorr, o_stat_timeouts} !== {8'd3, 8'd1, 8'd1}) begin
      n_fail++;
      $display("FAIL stats_case6: got %0d %0d %0d, want 3 1 1", o_stat_jobs, o_stat_uncorr, o_stat_timeouts);
    end
    for (int i = 0; i < 256; i++) begin
      run_job(1'b1, 1'b1, 15'($urandom), 15'($urandom), 1, 15'd0, 1'b1, 0, a);
    end
    n_cmp++;
    if ({o_stat_jobs, o_stat_uncorr, o_stat_timeouts} !== {8'd255, 8'd255, 8'd1}) begin
      n_fail++;
      $display("FAIL stats_saturate: got %0d %0d %0d, want 255 255 1",
               o_stat_jobs, o_stat_uncorr, o_stat_timeouts);
    end
  endtask
`endif

  initial begin
    rst = 1'b1;
    test_reset();
    test_case1();
    test_back_to_back();
    test_timeout();
    test_reset_midjob();
    test_random();
`ifdef BCH_DEC_CTRL_STATS_EN
    test_stats();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
